lc3b_mem_responder: RTL and testbench

Memory-side responder for the LC-3b CPU memory interface. It accepts the CPU's read and write requests and holds every request for a programmable number of cycles. It then completes each one with a single-cycle `mem_resp` pulse. Storage is a byte-maskable word array. The block is the far end of the CPU's `mem_*` port group and serves as the simulation and FPGA memory for the MP-series cores.

---
 rtl/lc3b_mem_responder.sv | 119 +++++++++++
 tb/tb_lc3b_mem_responder.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/lc3b_mem_responder.sv
// Memory-side responder for the LC-3b mem_* port group: fixed-latency handshake
// in front of a byte-maskable 16-bit word array.
module lc3b_mem_responder #(
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_byte_enable,
  input  logic [15:0] mem_address,
  input  logic [15:0] mem_wdata,
  output logic        mem_resp,
  output logic [15:0] mem_rdata
);

  localparam int         WORDS    = 2 ** (ADDR_BITS - 1);
  localparam int         IDX_BITS = ADDR_BITS - 1;
  localparam logic [3:0] LAST_CNT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          resp_q;
  logic [15:0]   rdata_q;
  logic          wr_op_q;
  logic          req;
  logic          enter_resp;
  logic [IDX_BITS-1:0] idx;
  logic          addr_unused_bits;

  logic [15:0]   mem_q [WORDS];

  assign req        = mem_read | mem_write;
  assign idx        = mem_address[ADDR_BITS-1:1];
  assign enter_resp = (state_d == S_RESP);

  // Bit 0 and everything above the decoded range alias and are deliberately dropped.
  assign addr_unused_bits = mem_address[0] ^ (^(mem_address >> ADDR_BITS));

  // NOTE: every variable assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          if (LATENCY == 1) begin
            state_d = S_RESP;
            cnt_d   = 4'd0;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'd1;
          end
        end
      end
      S_WAIT: begin
        // A dropped request aborts even on the cycle the count would complete.
        if (!req) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == LAST_CNT) begin
          state_d = S_RESP;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      resp_q  <= 1'b0;
      rdata_q <= 16'h0000;
      wr_op_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      resp_q  <= enter_resp;
      if (enter_resp) begin
        // Write wins over a simultaneous read; the op kind is frozen on RESP entry.
        wr_op_q <= mem_write;
        if (mem_read && !mem_write) begin
          rdata_q <= mem_q[idx];
        end
      end
    end
  end

  // NOTE: the array has no reset branch; contents persist across rst and start undefined.
  always_ff @(posedge clk) begin
    if (!rst && resp_q && wr_op_q) begin
      if (mem_byte_enable[0]) mem_q[idx][7:0]  <= mem_wdata[7:0];
      if (mem_byte_enable[1]) mem_q[idx][15:8] <= mem_wdata[15:8];
    end
  end

  assign mem_resp  = resp_q;
  assign mem_rdata = rdata_q;

endmodule

// File: tb/tb_lc3b_mem_responder.sv
// Self-checking bench for lc3b_mem_responder: directed plan plus random traffic
// against a byte-level memory model, on a LATENCY=3 and a LATENCY=1 instance.
module tb_lc3b_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd0, wr0, rd1, wr1;
  logic [1:0]  be0, be1;
  logic [15:0] addr0, addr1, wd0, wd1;
  logic        resp0, resp1;
  logic [15:0] rdata0, rdata1;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] model     [2][128];
  logic [1:0]  bvalid    [2][128];
  logic [15:0] exp_rdata [2];

  always #5 clk = ~clk;

  lc3b_mem_responder #(.ADDR_BITS(8), .LATENCY(3)) dut (
    .clk(clk), .rst(rst), .mem_read(rd0), .mem_write(wr0),
    .mem_byte_enable(be0), .mem_address(addr0), .mem_wdata(wd0),
    .mem_resp(resp0), .mem_rdata(rdata0)
  );

  lc3b_mem_responder #(.ADDR_BITS(8), .LATENCY(1)) dut_l1 (
    .clk(clk), .rst(rst), .mem_read(rd1), .mem_write(wr1),
    .mem_byte_enable(be1), .mem_address(addr1), .mem_wdata(wd1),
    .mem_resp(resp1), .mem_rdata(rdata1)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int lat(input bit sel);
    return sel ? 1 : 3;
  endfunction

  function automatic logic [15:0] obs_resp(input bit sel);
    return sel ? {15'd0, resp1} : {15'd0, resp0};
  endfunction

  function automatic logic [15:0] obs_rdata(input bit sel);
    return sel ? rdata1 : rdata0;
  endfunction

  task automatic set_in(input bit sel, input logic rd, input logic wr, input logic [15:0] a,
                        input logic [15:0] wd, input logic [1:0] be);
    if (sel) begin
      rd1 = rd; wr1 = wr; addr1 = a; wd1 = wd; be1 = be;
    end else begin
      rd0 = rd; wr0 = wr; addr0 = a; wd0 = wd; be0 = be;
    end
  endtask

  task automatic model_write(input bit sel, input logic [15:0] a, input logic [15:0] wd,
                             input logic [1:0] be);
    int ix = int'(a[7:1]);
    if (be[0]) begin model[sel][ix][7:0]  = wd[7:0];  bvalid[sel][ix][0] = 1'b1; end
    if (be[1]) begin model[sel][ix][15:8] = wd[15:8]; bvalid[sel][ix][1] = 1'b1; end
  endtask

  // Called at a falling edge with the DUT idle; returns at a falling edge with it idle again.
  task automatic txn(input bit sel, input logic rd, input logic wr, input logic [15:0] a,
                     input logic [15:0] wd, input logic [1:0] be, input string tag);
    int l = lat(sel);
    set_in(sel, rd, wr, a, wd, be);
    if (rd && !wr) exp_rdata[sel] = model[sel][int'(a[7:1])];
    for (int k = 1; k <= l; k++) begin
      @(negedge clk);
      check({tag, " resp"}, obs_resp(sel), 16'(k == l));
    end
    check({tag, " rdata"}, obs_rdata(sel), exp_rdata[sel]);
    set_in(sel, 1'b0, 1'b0, a, wd, be);
    @(negedge clk);
    check({tag, " resp_after"}, obs_resp(sel), 16'd0);
    check({tag, " rdata_hold"}, obs_rdata(sel), exp_rdata[sel]);
    if (wr) model_write(sel, a, wd, be);
  endtask

  // Read held high through its response: the second pulse lands LATENCY+1 cycles later.
  task automatic held_read(input bit sel, input logic [15:0] a, input string tag);
    int l = lat(sel);
    set_in(sel, 1'b1, 1'b0, a, 16'h0, 2'b00);
    exp_rdata[sel] = model[sel][int'(a[7:1])];
    for (int k = 1; k <= 2 * l + 1; k++) begin
      @(negedge clk);
      check({tag, " resp"}, obs_resp(sel), 16'((k == l) || (k == 2 * l + 1)));
    end
    check({tag, " rdata"}, obs_rdata(sel), exp_rdata[sel]);
    set_in(sel, 1'b0, 1'b0, a, 16'h0, 2'b00);
    @(negedge clk);
    check({tag, " resp_after"}, obs_resp(sel), 16'd0);
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 128; i++) bvalid[s][i] = 2'b00;
      exp_rdata[s] = 16'h0000;
    end
    rst = 1'b1;
    set_in(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0, 2'b00);
    set_in(1'b1, 1'b1, 1'b0, 16'h0010, 16'h0, 2'b00);

    // Reset held two cycles with a read pending.
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("rst resp", obs_resp(0), 16'd0);
      check("rst rdata", obs_rdata(0), 16'h0000);
      check("rst resp l1", obs_resp(1), 16'd0);
    end
    rst = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
    set_in(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
    @(negedge clk);
    check("post_rst resp", obs_resp(0), 16'd0);
    check("post_rst rdata", obs_rdata(0), 16'h0000);

    // Full write/read and byte masks.
    txn(0, 1'b0, 1'b1, 16'h0010, 16'hBEEF, 2'b11, "wr_beef");
    txn(0, 1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, "rd_beef");
    check("rd_beef value", exp_rdata[0], 16'hBEEF);
    txn(0, 1'b0, 1'b1, 16'h0010, 16'h1234, 2'b01, "wr_lo");
    txn(0, 1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, "rd_be34");
    check("be34 value", rdata0, 16'hBE34);
    txn(0, 1'b0, 1'b1, 16'h0010, 16'hAB00, 2'b10, "wr_hi");
    txn(0, 1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, "rd_ab34");
    check("ab34 value", rdata0, 16'hAB34);
    txn(0, 1'b0, 1'b1, 16'h0010, 16'hFFFF, 2'b00, "wr_nomask");
    txn(0, 1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, "rd_nomask");
    check("nomask value", rdata0, 16'hAB34);

    // Abort: write held two cycles then dropped.
    set_in(0, 1'b0, 1'b1, 16'h0010, 16'h0000, 2'b11);
    repeat (2) begin
      @(negedge clk);
      check("abort resp", obs_resp(0), 16'd0);
    end
    set_in(0, 1'b0, 1'b0, 16'h0010, 16'h0000, 2'b11);
    repeat (4) begin
      @(negedge clk);
      check("abort quiet", obs_resp(0), 16'd0);
    end
    txn(0, 1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, "rd_after_abort");
    check("abort value", rdata0, 16'hAB34);

    // Reset pulsed in the RESP cycle of a write discards the write.
    set_in(0, 1'b0, 1'b1, 16'h0010, 16'h0000, 2'b11);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("rstwr resp", obs_resp(0), 16'(k == 3));
    end
    rst = 1'b1;
    set_in(0, 1'b0, 1'b0, 16'h0010, 16'h0000, 2'b11);
    @(negedge clk);
    check("rstwr resp_after", obs_resp(0), 16'd0);
    check("rstwr rdata_cleared", obs_rdata(0), 16'h0000);
    rst = 1'b0;
    exp_rdata[0] = 16'h0000;
    exp_rdata[1] = 16'h0000;
    @(negedge clk);
    txn(0, 1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, "rd_after_rstwr");
    check("rstwr value", rdata0, 16'hAB34);

    // Aliasing modulo 2^ADDR_BITS, and bit 0 ignored.
    txn(0, 1'b0, 1'b1, 16'h0102, 16'h5A5A, 2'b11, "wr_alias");
    txn(0, 1'b1, 1'b0, 16'h0002, 16'h0000, 2'b00, "rd_alias2");
    check("alias2 value", rdata0, 16'h5A5A);
    txn(0, 1'b1, 1'b0, 16'h0003, 16'h0000, 2'b00, "rd_alias3");
    check("alias3 value", rdata0, 16'h5A5A);

    // Read+write together: write only, rdata untouched.
    txn(0, 1'b1, 1'b1, 16'h0010, 16'h7777, 2'b11, "rdwr");
    check("rdwr rdata kept", rdata0, 16'h5A5A);
    txn(0, 1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, "rd_after_rdwr");
    check("rdwr value", rdata0, 16'h7777);

    held_read(0, 16'h0010, "held_l3");

    // LATENCY=1 instance.
    txn(1, 1'b0, 1'b1, 16'h0040, 16'hC0DE, 2'b11, "l1_wr");
    txn(1, 1'b1, 1'b0, 16'h0040, 16'h0000, 2'b00, "l1_rd");
    check("l1 value", rdata1, 16'hC0DE);
    held_read(1, 16'h0040, "held_l1");

    // Random traffic against the model on both instances.
    for (int i = 0; i < 60; i++) begin
      bit          sel = (i % 3 == 2);
      logic [15:0] a   = 16'($urandom);
      logic [15:0] wd  = 16'($urandom);
      logic [1:0]  be  = 2'($urandom);
      int          op  = int'($urandom_range(0, 2));
      logic        rd  = (op != 1);
      logic        wr  = (op != 0);
      if (!wr && bvalid[sel][int'(a[7:1])] != 2'b11) begin
        wr = 1'b1;
        be = 2'b11;
      end
      txn(sel, rd, wr, a, wd, be, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
